hazard_response_stage: RTL and testbench

//  Consumer of the hazard unit's stall/forward decisions. Holds fetch PC, injects bubbles into the
//  ID->EX register on stall, substitutes the writeback result into EX operands when forwarding is

---
 rtl/hazard_response_stage_pkg.sv | 34 +++
 rtl/hazard_response_stage_operand_forward_mux.sv | 17 +
 rtl/hazard_response_stage.sv | 138 +++++++++++++
 tb/tb_hazard_response_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_response_stage_pkg.sv
// Shared CPU types for the hazard response stage: word/register typedefs, FSM states, EX register layout.
package hazard_response_stage_pkg;

  localparam int CPU_XLEN = 32;

  typedef logic [CPU_XLEN-1:0] Word;
  typedef logic [CPU_XLEN-1:0] Addr;
  typedef logic [4:0]          RegId;
  typedef logic                Bool;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } HazardState;

  localparam Addr PC_STEP = 32'd4;

  typedef struct packed {
    Bool  valid;
    Addr  pc;
    Word  op1;
    Word  op2;
    RegId rd;
  } ExStage;

  localparam ExStage EX_BUBBLE = '0;

  // Saturating event counter step; holds at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_response_stage_operand_forward_mux.sv
// Per-operand 2:1 select between the regfile read and the writeback result.
module operand_forward_mux #(
  parameter int XLEN = 32
) (
  input  logic            fwd1_enable,
  input  logic            fwd2_enable,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2
);

  assign op1 = fwd1_enable ? wb_data : rs1_val;
  assign op2 = fwd2_enable ? wb_data : rs2_val;

endmodule

// File: rtl/hazard_response_stage.sv
// Applies hazard unit decisions between decode and execute: PC hold, stall bubbles, forwarding, branch squash.
// Optional HAZARD_STATS_EN adds saturating stall/flush bubble counters.
module hazard_response_stage
  import hazard_response_stage_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              FLUSH_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            fwd1_enable_in,
  input  logic            fwd2_enable_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            id_valid_in,
  input  logic [XLEN-1:0] id_pc_in,
  input  logic [XLEN-1:0] id_rs1_val_in,
  input  logic [XLEN-1:0] id_rs2_val_in,
  input  logic [4:0]      id_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic [XLEN-1:0] pc_out,
  output logic            if_id_hold_out,
  output logic            ex_valid_out,
  output logic [XLEN-1:0] ex_pc_out,
  output logic [XLEN-1:0] ex_op1_out,
  output logic [XLEN-1:0] ex_op2_out,
  output logic [4:0]      ex_rd_out,
  output logic            flushing_out
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_count_out,
  output logic [31:0]     flush_count_out
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

  HazardState      state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0] pc_q;
  ExStage          ex_q;
  logic [XLEN-1:0] fwd_op1, fwd_op2;

  logic            stall_bubble;
  logic            flush_bubble;
  logic            inject_bubble;

  operand_forward_mux #(.XLEN(XLEN)) u_fwd_mux (
    .fwd1_enable (fwd1_enable_in),
    .fwd2_enable (fwd2_enable_in),
    .rs1_val     (id_rs1_val_in),
    .rs2_val     (id_rs2_val_in),
    .wb_data     (wb_data_in),
    .op1         (fwd_op1),
    .op2         (fwd_op2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Leaving FLUSH on the cycle the count reaches zero gives FLUSH_DEPTH bubbles including the branch cycle.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken_in) begin
      state_d     = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
      flush_cnt_d = FLUSH_RELOAD;
    end else begin
      case (state_q)
        RUN, STALL: state_d = stall_in ? STALL : RUN;
        FLUSH: begin
          flush_cnt_d = (flush_cnt_q == 3'd0) ? 3'd0 : flush_cnt_q - 3'd1;
          state_d     = (flush_cnt_q <= 3'd1) ? RUN : FLUSH;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    flush_bubble   = branch_taken_in || (state_q == FLUSH);
    stall_bubble   = stall_in && !flush_bubble;
    inject_bubble  = flush_bubble || stall_bubble;
    if_id_hold_out = stall_bubble;
    flushing_out   = (state_q == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ex_q <= EX_BUBBLE;
    end else begin
      if (branch_taken_in)   pc_q <= branch_target_in;
      else if (!stall_bubble) pc_q <= pc_q + XLEN'(PC_STEP);

      if (inject_bubble) begin
        ex_q <= EX_BUBBLE;
      end else begin
        ex_q.valid <= id_valid_in;
        ex_q.pc    <= id_pc_in;
        ex_q.op1   <= fwd_op1;
        ex_q.op2   <= fwd_op2;
        ex_q.rd    <= id_valid_in ? id_rd_in : 5'd0;
      end
    end
  end

  assign pc_out       = pc_q;
  assign ex_valid_out = ex_q.valid;
  assign ex_pc_out    = ex_q.pc;
  assign ex_op1_out   = ex_q.op1;
  assign ex_op2_out   = ex_q.op2;
  assign ex_rd_out    = ex_q.rd;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_out <= 32'd0;
      flush_count_out <= 32'd0;
    end else begin
      if (stall_bubble) stall_count_out <= sat_inc(stall_count_out);
      if (flush_bubble) flush_count_out <= sat_inc(flush_count_out);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_response_stage.sv
// Scoreboard bench for hazard_response_stage: expected EX contents queued at drive time, popped after each edge.
module tb_hazard_response_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, fwd1_enable_in, fwd2_enable_in, branch_taken_in;
  logic [31:0] branch_target_in;
  logic        id_valid_in;
  logic [31:0] id_pc_in, id_rs1_val_in, id_rs2_val_in, wb_data_in;
  logic [4:0]  id_rd_in;
  logic [31:0] pc_out, ex_pc_out, ex_op1_out, ex_op2_out;
  logic        if_id_hold_out, ex_valid_out, flushing_out;
  logic [4:0]  ex_rd_out;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_out, flush_count_out;
`endif

  always #5 clk = ~clk;

  hazard_response_stage #(.XLEN(32), .FLUSH_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_in         (stall_in),
    .fwd1_enable_in   (fwd1_enable_in),
    .fwd2_enable_in   (fwd2_enable_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .id_valid_in      (id_valid_in),
    .id_pc_in         (id_pc_in),
    .id_rs1_val_in    (id_rs1_val_in),
    .id_rs2_val_in    (id_rs2_val_in),
    .id_rd_in         (id_rd_in),
    .wb_data_in       (wb_data_in),
    .pc_out           (pc_out),
    .if_id_hold_out   (if_id_hold_out),
    .ex_valid_out     (ex_valid_out),
    .ex_pc_out        (ex_pc_out),
    .ex_op1_out       (ex_op1_out),
    .ex_op2_out       (ex_op2_out),
    .ex_rd_out        (ex_rd_out),
    .flushing_out     (flushing_out)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count_out  (stall_count_out),
    .flush_count_out  (flush_count_out)
`endif
  );

  logic [101:0] sbq[$];
  wire  [101:0] ex_act = {ex_valid_out, ex_pc_out, ex_op1_out, ex_op2_out, ex_rd_out};
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [31:0]  exp_pc;
  int           exp_stalls, exp_flushes;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; stall_in = 1'b0; fwd1_enable_in = 1'b0; fwd2_enable_in = 1'b0;
    branch_taken_in = 1'b0; branch_target_in = '0; id_valid_in = 1'b0; id_pc_in = '0;
    id_rs1_val_in = '0; id_rs2_val_in = '0; id_rd_in = '0; wb_data_in = '0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] rd);
    id_valid_in = 1'b1; id_pc_in = pc; id_rs1_val_in = r1; id_rs2_val_in = r2; id_rd_in = rd;
  endtask

  task automatic push_ex(input logic v, input logic [31:0] pc, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [4:0] rd);
    sbq.push_back({v, pc, o1, o2, rd});
  endtask

  task automatic push_bubble();
    sbq.push_back('0);
  endtask

  task automatic test_reset();
    logic [101:0] e;
    idle();
    rst_n = 1'b0; stall_in = 1'b1; drive_id(32'h50, 32'h1, 32'h2, 5'd3);
    tick(); tick();
    e = '0;
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL reset_ex got=%h exp=%h", ex_act, e); end
    n_cmp++; if (flushing_out !== 1'b0) begin n_bad++; $display("FAIL reset_flushing got=%b exp=0", flushing_out); end
`ifdef HAZARD_STATS_EN
    n_cmp++; if ({stall_count_out, flush_count_out} !== 64'h0) begin
      n_bad++; $display("FAIL reset_stats got=%h/%h exp=0/0", stall_count_out, flush_count_out);
    end
`endif
    idle();
    exp_pc = 32'h0; exp_stalls = 0; exp_flushes = 0;
  endtask

  task automatic test_stream();
    logic [101:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_id(32'(i * 4), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 5'(i + 1));
      push_ex(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 5'(i + 1));
      tick();
      exp_pc = exp_pc + 32'd4;
      n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, pc_out, exp_pc); end
      e = sbq.pop_front();
      n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL stream_ex%0d got=%h exp=%h", i, ex_act, e); end
    end
  endtask

  task automatic test_stall();
    logic [101:0] e;
    // Single stall; forward flags set to confirm they do not leak into the bubble.
    stall_in = 1'b1; fwd1_enable_in = 1'b1; wb_data_in = 32'hDEAD;
    drive_id(32'h8, 32'h31, 32'h32, 5'd4);
    #1;
    n_cmp++; if (if_id_hold_out !== 1'b1) begin n_bad++; $display("FAIL stall_hold got=%b exp=1", if_id_hold_out); end
    push_bubble(); exp_stalls++;
    tick();
    n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL stall_pc_held got=%h exp=%h", pc_out, exp_pc); end
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL stall_bubble got=%h exp=%h", ex_act, e); end
    stall_in = 1'b0; fwd1_enable_in = 1'b0;
    push_ex(1'b1, 32'h8, 32'h31, 32'h32, 5'd4);
    #1;
    n_cmp++; if (if_id_hold_out !== 1'b0) begin n_bad++; $display("FAIL stall_release_hold got=%b exp=0", if_id_hold_out); end
    tick();
    exp_pc = exp_pc + 32'd4;
    n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL stall_resume_pc got=%h exp=%h", pc_out, exp_pc); end
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL stall_resume_ex got=%h exp=%h", ex_act, e); end
    // Repeated stall stays held for both cycles.
    stall_in = 1'b1; drive_id(32'hC, 32'h41, 32'h42, 5'd5);
    for (int k = 0; k < 2; k++) begin
      push_bubble(); exp_stalls++;
      tick();
      n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL stall_rep_pc%0d got=%h exp=%h", k, pc_out, exp_pc); end
      e = sbq.pop_front();
      n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL stall_rep_ex%0d got=%h exp=%h", k, ex_act, e); end
    end
    stall_in = 1'b0;
    push_ex(1'b1, 32'hC, 32'h41, 32'h42, 5'd5);
    tick();
    exp_pc = exp_pc + 32'd4;
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL stall_rep_resume got=%h exp=%h", ex_act, e); end
  endtask

  task automatic test_forward();
    logic [101:0] e;
    logic [1:0]   flags [4];
    flags[0] = 2'b10; flags[1] = 2'b11; flags[2] = 2'b01; flags[3] = 2'b00;
    wb_data_in = 32'hAA;
    for (int k = 0; k < 4; k++) begin
      {fwd1_enable_in, fwd2_enable_in} = flags[k];
      drive_id(32'h40 + 32'(4 * k), 32'h5, 32'h6, 5'd9);
      push_ex(1'b1, 32'h40 + 32'(4 * k), flags[k][1] ? 32'hAA : 32'h5, flags[k][0] ? 32'hAA : 32'h6, 5'd9);
      tick();
      exp_pc = exp_pc + 32'd4;
      e = sbq.pop_front();
      n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL forward_ex%0d got=%h exp=%h", k, ex_act, e); end
    end
    // Invalid decode slot: operands and pc still load, destination forced to zero.
    fwd1_enable_in = 1'b0; fwd2_enable_in = 1'b0;
    drive_id(32'h60, 32'h7, 32'h8, 5'd7); id_valid_in = 1'b0;
    push_ex(1'b0, 32'h60, 32'h7, 32'h8, 5'd0);
    tick();
    exp_pc = exp_pc + 32'd4;
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL invalid_id_ex got=%h exp=%h", ex_act, e); end
    n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL forward_pc got=%h exp=%h", pc_out, exp_pc); end
  endtask

  task automatic test_branch_stall();
    logic [101:0] e;
    stall_in = 1'b1; branch_taken_in = 1'b1; branch_target_in = 32'h100;
    drive_id(32'h70, 32'h1, 32'h2, 5'd3);
    #1;
    n_cmp++; if (if_id_hold_out !== 1'b0) begin n_bad++; $display("FAIL branch_hold got=%b exp=0", if_id_hold_out); end
    push_bubble(); exp_flushes++;
    tick();
    exp_pc = 32'h100;
    branch_taken_in = 1'b0; stall_in = 1'b0;
    n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL branch_pc got=%h exp=%h", pc_out, exp_pc); end
    n_cmp++; if (flushing_out !== 1'b1) begin n_bad++; $display("FAIL branch_flushing got=%b exp=1", flushing_out); end
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL branch_bubble0 got=%h exp=%h", ex_act, e); end
    push_bubble(); exp_flushes++;
    tick();
    exp_pc = exp_pc + 32'd4;
    n_cmp++; if (pc_out !== 32'h104) begin n_bad++; $display("FAIL flush_pc got=%h exp=%h", pc_out, 32'h104); end
    n_cmp++; if (flushing_out !== 1'b0) begin n_bad++; $display("FAIL flush_exit got=%b exp=0", flushing_out); end
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL branch_bubble1 got=%h exp=%h", ex_act, e); end
    drive_id(32'h104, 32'h11, 32'h12, 5'd13);
    push_ex(1'b1, 32'h104, 32'h11, 32'h12, 5'd13);
    tick();
    exp_pc = exp_pc + 32'd4;
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL post_flush_ex got=%h exp=%h", ex_act, e); end
    n_cmp++; if (pc_out !== exp_pc) begin n_bad++; $display("FAIL post_flush_pc got=%h exp=%h", pc_out, exp_pc); end
  endtask

  task automatic test_stats();
`ifdef HAZARD_STATS_EN
    n_cmp++; if (stall_count_out !== 32'(exp_stalls)) begin
      n_bad++; $display("FAIL stall_count got=%0d exp=%0d", stall_count_out, exp_stalls);
    end
    n_cmp++; if (flush_count_out !== 32'(exp_flushes)) begin
      n_bad++; $display("FAIL flush_count got=%0d exp=%0d", flush_count_out, exp_flushes);
    end
`endif
  endtask

  task automatic test_branch_in_flush();
    logic [101:0] e;
    drive_id(32'h90, 32'h1, 32'h2, 5'd3);
    branch_taken_in = 1'b1; branch_target_in = 32'h180;
    push_bubble(); tick();
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL rebranch_bubble0 got=%h exp=%h", ex_act, e); end
    branch_target_in = 32'h200;
    push_bubble(); tick();
    n_cmp++; if (pc_out !== 32'h200) begin n_bad++; $display("FAIL rebranch_pc got=%h exp=%h", pc_out, 32'h200); end
    n_cmp++; if (flushing_out !== 1'b1) begin n_bad++; $display("FAIL rebranch_flushing got=%b exp=1", flushing_out); end
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL rebranch_bubble1 got=%h exp=%h", ex_act, e); end
    branch_taken_in = 1'b0;
    push_bubble(); tick();
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL rebranch_bubble2 got=%h exp=%h", ex_act, e); end
    n_cmp++; if (flushing_out !== 1'b0) begin n_bad++; $display("FAIL rebranch_exit got=%b exp=0", flushing_out); end
    drive_id(32'h204, 32'h21, 32'h22, 5'd23);
    push_ex(1'b1, 32'h204, 32'h21, 32'h22, 5'd23);
    tick();
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL rebranch_issue got=%h exp=%h", ex_act, e); end
  endtask

  task automatic test_pc_wrap();
    branch_taken_in = 1'b1; branch_target_in = 32'hFFFF_FFF8;
    tick();
    branch_taken_in = 1'b0;
    tick();
    n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc_top got=%h exp=%h", pc_out, 32'hFFFF_FFFC); end
    tick();
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL wrap_pc_zero got=%h exp=%h", pc_out, 32'h0); end
  endtask

  task automatic test_reset_mid_flush();
    logic [101:0] e;
    branch_taken_in = 1'b1; branch_target_in = 32'h300;
    tick();
    branch_taken_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    e = '0;
    n_cmp++; if (flushing_out !== 1'b0) begin n_bad++; $display("FAIL midreset_flushing got=%b exp=0", flushing_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL midreset_pc got=%h exp=%h", pc_out, 32'h0); end
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL midreset_ex got=%h exp=%h", ex_act, e); end
    drive_id(32'h0, 32'h51, 32'h52, 5'd17);
    push_ex(1'b1, 32'h0, 32'h51, 32'h52, 5'd17);
    tick();
    e = sbq.pop_front();
    n_cmp++; if (ex_act !== e) begin n_bad++; $display("FAIL midreset_issue got=%h exp=%h", ex_act, e); end
    n_cmp++; if (pc_out !== 32'h4) begin n_bad++; $display("FAIL midreset_pc_step got=%h exp=%h", pc_out, 32'h4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_forward();
    test_branch_stall();
    test_stats();
    test_branch_in_flush();
    test_pc_wrap();
    test_reset_mid_flush();
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
